icache_nway: RTL

- Parametrised successor to the 2-way instruction cache: N-way set-associative, configurable set count and line length, read-only from the CPU side.
- Sits between the IF stage and the AXI bridge read channel.
- Adds over the previous generation:
  - per-set round-robin replacement;
  - burst length output;
  - valid-bit clear on reset;
  - refill drain on a cancelled fetch.
- Data and tag storage are internal synchronous-read arrays.

---
 rtl/icache_nway.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/icache_nway.sv
// rtl/icache_nway.sv - N-way set-associative read-only instruction cache
module icache_nway #(
  parameter  int WAYS       = 4,
  parameter  int INDEX_W    = 8,
  parameter  int LINE_WORDS = 4,
  localparam int OFFSET_W   = $clog2(LINE_WORDS) + 2,
  localparam int TAG_W      = 32 - INDEX_W - OFFSET_W,
  localparam int WAY_W      = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                valid,
  input  logic [INDEX_W-1:0]  index,
  input  logic [TAG_W-1:0]    tag,
  input  logic [OFFSET_W-1:0] offset,
  input  logic                uncache_en,
  input  logic                tlb_excp_cancel_req,
  input  logic                icacop_op_en,
  input  logic [1:0]          cacop_op_mode,
  input  logic [INDEX_W-1:0]  cacop_op_addr_index,
  input  logic [TAG_W-1:0]    cacop_op_addr_tag,
  input  logic [OFFSET_W-1:0] cacop_op_addr_offset,
  output logic                addr_ok,
  output logic                data_ok,
  output logic [31:0]         rdata,
  output logic                icache_unbusy,
  output logic                rd_req,
  output logic [2:0]          rd_type,
  output logic [7:0]          rd_len,
  output logic [31:0]         rd_addr,
  input  logic                rd_rdy,
  input  logic                ret_valid,
  input  logic                ret_last,
  input  logic [31:0]         ret_data,
  output logic                cache_miss
);

  localparam int SETS   = 1 << INDEX_W;
  localparam int WORD_W = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MISS, S_REFILL} state_t;
  state_t state_q, state_d;

  // Storage: data/tag are plain RAMs, valid bits and round-robin pointers are flops
  logic [31:0]      data_mem [WAYS][SETS*LINE_WORDS];
  logic [TAG_W-1:0] tag_mem  [WAYS][SETS];
  logic [WAYS-1:0]  valid_q  [SETS];
  logic [WAY_W-1:0] rr_q     [SETS];

  logic [31:0]      word_rd_q [WAYS];
  logic [TAG_W-1:0] tag_rd_q  [WAYS];

  logic [INDEX_W-1:0]  idx_q;
  logic [OFFSET_W-1:0] off_q;
  logic                cacop_q;
  logic [1:0]          mode_q;
  logic [TAG_W-1:0]    tag_q;
  logic                unc_q;
  logic [WAY_W-1:0]    victim_q;
  logic [WORD_W-1:0]   cnt_q;
  logic                drop_q;

  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic [TAG_W-1:0]    cmp_tag;
  logic [WAYS-1:0]     way_hit;
  logic [WAY_W-1:0]    hit_way;
  logic [WAY_W-1:0]    victim;
  logic [WORD_W-1:0]   word_sel;
  logic                hit, accept, goes_miss, ret_beat, refill_done, cacop_clr;

  assign req_idx     = icacop_op_en ? cacop_op_addr_index  : index;
  assign req_off     = icacop_op_en ? cacop_op_addr_offset : offset;
  assign cmp_tag     = cacop_q ? cacop_op_addr_tag : tag;
  assign word_sel    = off_q[OFFSET_W-1:2];
  assign hit         = (state_q == S_LOOKUP) && (|way_hit) && !uncache_en && !cacop_q;
  assign addr_ok     = ((state_q == S_IDLE) || hit) && !icacop_op_en;
  assign accept      = (addr_ok && valid) || (icacop_op_en && ((state_q == S_IDLE) || hit));
  assign goes_miss   = (state_q == S_LOOKUP) && (state_d == S_MISS);
  assign ret_beat    = (state_q == S_REFILL) && ret_valid;
  assign refill_done = ret_beat && ret_last && !unc_q;
  assign cacop_clr   = (state_q == S_LOOKUP) && cacop_q;

  assign icache_unbusy = (state_q == S_IDLE);
  assign rd_type       = unc_q ? 3'b010 : 3'b100;
  assign rd_len        = unc_q ? 8'd0 : 8'(LINE_WORDS - 1);
  assign rd_addr       = unc_q ? {tag_q, idx_q, off_q} : {tag_q, idx_q, {OFFSET_W{1'b0}}};

  // Tag compare across ways and victim choice (lowest invalid way, else round-robin)
  always_comb begin
    way_hit = '0;
    hit_way = '0;
    victim  = rr_q[idx_q];
    for (int w = 0; w < WAYS; w++) begin
      way_hit[w] = valid_q[idx_q][w] && (tag_rd_q[w] == cmp_tag);
      if (way_hit[w]) hit_way = WAY_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[idx_q][w]) victim = WAY_W'(w);
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and CPU/bridge handshake outputs
  always_comb begin
    state_d    = state_q;
    data_ok    = 1'b0;
    rdata      = '0;
    rd_req     = 1'b0;
    cache_miss = 1'b0;
    case (state_q)
      S_IDLE: if (accept) state_d = S_LOOKUP;
      S_LOOKUP: begin
        data_ok = !cacop_q && (hit || tlb_excp_cancel_req);
        rdata   = hit ? word_rd_q[hit_way] : '0;
        if (accept)                                         state_d = S_LOOKUP;
        else if (cacop_q || hit || tlb_excp_cancel_req)     state_d = S_IDLE;
        else                                                state_d = S_MISS;
      end
      S_MISS: begin
        rd_req = 1'b1;
        if (rd_rdy) state_d = S_REFILL;
      end
      S_REFILL: begin
        if (ret_valid) begin
          rdata   = ret_data;
          data_ok = !drop_q && !tlb_excp_cancel_req &&
                    (unc_q ? (cnt_q == '0) : (cnt_q == word_sel));
          if (ret_last) begin
            state_d    = S_IDLE;
            cache_miss = !unc_q;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request capture, miss bookkeeping, beat counter and cancel-drop flag
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx_q    <= '0;
      off_q    <= '0;
      cacop_q  <= 1'b0;
      mode_q   <= '0;
      tag_q    <= '0;
      unc_q    <= 1'b0;
      victim_q <= '0;
      cnt_q    <= '0;
      drop_q   <= 1'b0;
    end else begin
      if (accept) begin
        idx_q   <= req_idx;
        off_q   <= req_off;
        cacop_q <= icacop_op_en;
        mode_q  <= cacop_op_mode;
      end
      if (goes_miss) begin
        tag_q    <= tag;
        unc_q    <= uncache_en;
        victim_q <= victim;
      end
      if ((state_q == S_MISS) && rd_rdy) cnt_q <= '0;
      else if (ret_beat)                 cnt_q <= cnt_q + WORD_W'(1);
      if (state_q == S_IDLE) drop_q <= 1'b0;
      else if (((state_q == S_MISS) || (state_q == S_REFILL)) && tlb_excp_cancel_req) drop_q <= 1'b1;
    end
  end

  // Synchronous-read RAMs: all ways read on accept, refill writes the victim way
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int w = 0; w < WAYS; w++) begin
        word_rd_q[w] <= data_mem[w][{req_idx, req_off[OFFSET_W-1:2]}];
        tag_rd_q[w]  <= tag_mem[w][req_idx];
      end
    end
    if (ret_beat && !unc_q) data_mem[victim_q][{idx_q, cnt_q}] <= ret_data;
    if (refill_done)        tag_mem[victim_q][idx_q] <= tag_q;
  end

  // Valid bits and replacement pointers, cleared on reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else begin
      if (refill_done) begin
        valid_q[idx_q][victim_q] <= 1'b1;
        rr_q[idx_q]              <= rr_q[idx_q] + WAY_W'(1);
      end
      if (cacop_clr) begin
        if (mode_q == 2'b10) begin
          if (|way_hit) valid_q[idx_q][hit_way] <= 1'b0;
        end else begin
          valid_q[idx_q][off_q[WAY_W-1:0]] <= 1'b0;
        end
      end
    end
  end

endmodule
